// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and sizes for the truth table sweeper
package sweep_pkg;
    localparam int NUM_COMBOS = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: loadable down-counter with an expire flag at zero
module sweep_settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = cnt == '0;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 3-input combinations and checks dut_out against a truth table
// SWEEP_EARLY_ABORT_EN: stop at the first mismatching combination
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic [2:0] dut_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed,
    output logic [2:0] first_fail,
    output logic [3:0] mismatch_count
);
    // the timer is loaded on leaving APPLY, so SETTLE ends on the cycle it reads zero
    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COMBOS - 1);
    state_t state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] bit_pos;
    logic [CNT_W-1:0] cnt_next;
    logic miss;
    logic finish;
    logic expired;
    assign bit_pos = LAST_IDX - idx;
    assign miss = dut_out != expected[bit_pos];
    assign cnt_next = mismatch_count + CNT_W'(miss);
`ifdef SWEEP_EARLY_ABORT_EN
    assign finish = miss || idx == LAST_IDX;
`else
    assign finish = idx == LAST_IDX;
`endif
    assign dut_in = idx;
    sweep_settle_timer #(.W(8)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(state == APPLY),
        .value(SETTLE_LOAD),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            observed <= '0;
            first_fail <= '0;
            mismatch_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= APPLY;
                    idx <= '0;
                    busy <= 1'b1;
                    done <= 1'b0;
                    pass <= 1'b0;
                    observed <= '0;
                    first_fail <= '0;
                    mismatch_count <= '0;
                end
                APPLY: state <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                SETTLE: if (expired) state <= SAMPLE;
                SAMPLE: begin
                    observed[bit_pos] <= dut_out;
                    if (miss) begin
                        mismatch_count <= cnt_next;
                        if (mismatch_count == '0) first_fail <= idx;
                    end
                    if (finish) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= cnt_next == '0;
                    end else begin
                        state <= APPLY;
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized sweeps against a table-level reference model
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, start, start0;
    logic [7:0] expected, expected0, ftab, ftab0;
    logic dut_out, dut_out0;
    logic [2:0] dut_in, dut_in0, first_fail, first_fail0;
    logic busy, done, pass, busy0, done0, pass0;
    logic [7:0] observed, observed0;
    logic [3:0] mismatch_count, mismatch_count0;
    int checks = 0;
    int fails = 0;
    // the function under test is a lookup in ftab using the same bit order as expected
    assign dut_out = ftab[3'd7 - dut_in];
    assign dut_out0 = ftab0[3'd7 - dut_in0];
    truth_table_sweeper #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .dut_out(dut_out),
        .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .observed(observed),
        .first_fail(first_fail), .mismatch_count(mismatch_count)
    );
    truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(expected0), .dut_out(dut_out0),
        .dut_in(dut_in0), .busy(busy0), .done(done0), .pass(pass0), .observed(observed0),
        .first_fail(first_fail0), .mismatch_count(mismatch_count0)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask
    function automatic void model(input logic [7:0] f, input logic [7:0] e, input int s,
                                  output logic [7:0] obs, output int cnt, output int ff, output int lat);
        obs = '0;
        cnt = 0;
        ff = 0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            obs[7-i] = f[7-i];
            lat += s + 2;
            if (f[7-i] != e[7-i]) begin
                if (cnt == 0) ff = i;
                cnt++;
`ifdef SWEEP_EARLY_ABORT_EN
                break;
`endif
            end
        end
    endfunction
    task automatic wait_done(inout int n);
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
    task automatic check_result(input string tag, input logic [7:0] f, input logic [7:0] e, input int n);
        logic [7:0] obs;
        int cnt, ff, lat;
        model(f, e, 4, obs, cnt, ff, lat);
        check({tag, ".latency"}, n, lat);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".pass"}, pass, cnt == 0);
        check({tag, ".observed"}, observed, obs);
        check({tag, ".count"}, mismatch_count, cnt);
        check({tag, ".first_fail"}, first_fail, ff);
    endtask
    task automatic run4(input string tag, input logic [7:0] f, input logic [7:0] e, input bit repulse);
        int n = 0;
        ftab = f;
        expected = e;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy_up"}, busy, 1);
        if (repulse) begin
            repeat (10) begin @(posedge clk); #1; n++; end
            start = 1'b1;
            @(posedge clk); #1; n++;
            start = 1'b0;
            check({tag, ".still_busy"}, busy, 1);
        end
        wait_done(n);
        check_result(tag, f, e, n);
    endtask
    task automatic run0(input string tag, input logic [7:0] f, input logic [7:0] e);
        logic [7:0] obs;
        int cnt, ff, lat;
        int n = 0;
        ftab0 = f;
        expected0 = e;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        model(f, e, 0, obs, cnt, ff, lat);
        while (!done0 && n < 500) begin
            if (n < lat) check({tag, ".seq"}, dut_in0, n / 2);
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, n, lat);
        check({tag, ".pass"}, pass0, cnt == 0);
        check({tag, ".observed"}, observed0, obs);
        check({tag, ".count"}, mismatch_count0, cnt);
    endtask
    initial begin
        int n;
        logic [7:0] f, e;
        rst = 1'b1;
        start = 1'b0;
        start0 = 1'b0;
        expected = '0;
        expected0 = '0;
        ftab = '0;
        ftab0 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.outs", {dut_in, busy, done, pass, observed, first_fail, mismatch_count}, 0);
        run4("rule35", 8'h35, 8'h35, 1'b0);
        run4("tied0", 8'h00, 8'h35, 1'b0);
        run0("settle0", 8'hFF, 8'hFF);
        run4("repulse", 8'h35, 8'h35, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        check("restart.done", done, 0);
        check("restart.busy", busy, 1);
        check("restart.observed", observed, 0);
        start = 1'b0;
        n = 0;
        wait_done(n);
        check_result("restart", ftab, expected, n);
        ftab = 8'hA6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.outs", {dut_in, busy, done, pass, observed, first_fail, mismatch_count}, 0);
        run4("after_rst", 8'h35, 8'h35, 1'b0);
        for (int k = 0; k < 8; k++) begin
            f = 8'($urandom);
            e = ($urandom_range(0, 2) == 0) ? f : 8'($urandom);
            run4($sformatf("rand4_%0d", k), f, e, 1'b0);
            f = 8'($urandom);
            e = ($urandom_range(0, 2) == 0) ? f : 8'($urandom);
            run0($sformatf("rand0_%0d", k), f, e);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: idle cycles between driving a combination and sampling the function output (range 0..255).
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a full sweep; accepted only in IDLE or DONE.
REQ-005 expected  input  8  expected truth table; bit 7 is combination 3'b000, bit 0 is 3'b111 (0x35 naming convention).
REQ-006 dut_out  input  1  output of the 3-input function under test.
REQ-007 dut_in  output  3  combination driven as {in1,in2,in3}.
REQ-008 busy  output  1  high from start acceptance until DONE is entered.
REQ-009 done  output  1  high while in DONE; held until the next accepted start or rst.
REQ-010 pass  output  1  observed equals expected over all swept combinations; valid while done=1.
REQ-011 observed  output  8  captured truth table, same bit order as expected.
REQ-012 first_fail  output  3  index of the first mismatching combination; 3'd0 when pass=1.
REQ-013 mismatch_count  output  4  number of mismatching combinations, 0..8.

Function
REQ-014 The FSM SHALL have states IDLE, APPLY, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL clear observed, mismatch_count and first_fail, set idx=0 and enter APPLY.
REQ-016 APPLY SHALL drive dut_in=idx for one cycle, then go to SETTLE, or to SAMPLE if SETTLE_CYCLES=0.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles with dut_in held, then go to SAMPLE.
REQ-018 SAMPLE SHALL write dut_out into observed[7-idx] and compare it with expected[7-idx].
REQ-019 On a mismatch, SAMPLE SHALL increment mismatch_count and, if it was 0, load first_fail=idx.
REQ-020 After SAMPLE, idx<7 SHALL increment idx and go to APPLY; idx=7 SHALL enter DONE.
REQ-021 dut_in SHALL hold its last value in DONE and be 3'd0 in IDLE.
REQ-022 Latency from the start-accept edge to done=1 SHALL be 8*(SETTLE_CYCLES+2) cycles.
REQ-023 pass SHALL equal (mismatch_count==0) and be registered on entry to DONE.
REQ-024 start while busy SHALL be ignored; a start asserted in DONE SHALL restart in the same edge (done falls, busy rises).
REQ-025 The expected input SHALL be sampled only during SAMPLE; changing it mid-sweep affects only remaining combinations.
REQ-026 idx arithmetic is 3-bit; idx SHALL NOT wrap past 7 during a sweep.

Reset
REQ-027 rst=1 SHALL force IDLE regardless of state, including mid-sweep.
REQ-028 On reset, outputs SHALL be: dut_in=0, busy=0, done=0, pass=0, observed=0, first_fail=0, mismatch_count=0; settle counter and idx SHALL be 0.
REQ-029 rst SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro SWEEP_EARLY_ABORT_EN: when defined, the first mismatch in SAMPLE SHALL enter DONE immediately with pass=0, mismatch_count=1, first_fail=idx, and unswept observed bits left at 0.
REQ-031 When SWEEP_EARLY_ABORT_EN is undefined, all 8 combinations SHALL always be swept.

Structure
REQ-032 Package sweep_pkg SHALL hold the state enum, NUM_COMBOS=8, IDX_W=3 and CNT_W=4.
REQ-033 The settle counter SHALL be a sub-module, sweep_settle_timer (load, count down, expire flag); everything else stays in truth_table_sweeper.

Verification
REQ-034 DUT = rule 0x35 function, expected=8'h35, SETTLE_CYCLES=4, pulse start -> done at +48 cycles, pass=1, observed=8'h35, mismatch_count=0.
REQ-035 dut_out tied 0, expected=8'h35 -> pass=0, mismatch_count=4, first_fail=3'd2; with SWEEP_EARLY_ABORT_EN: done after 3 combinations (18 cycles), mismatch_count=1.
REQ-036 SETTLE_CYCLES=0, expected=8'hFF, dut_out tied 1 -> done at +16 cycles, pass=1, dut_in sequence 0..7 one value per 2 cycles.
REQ-037 rst asserted at cycle 20 of a sweep -> next cycle IDLE, all outputs zero; a new start completes normally.
REQ-038 start re-pulsed while busy -> ignored, single done at +48; start held high in DONE -> immediate restart, observed cleared.
